dmem_store_buffer: RTL and testbench

//  Posted-write store buffer between the mips data port and dmem.

---
 rtl/mips_pkg.sv | 23 ++
 rtl/sb_fwd_select.sv | 45 ++++
 rtl/dmem_store_buffer.sv | 117 +++++++++++
 tb/tb_dmem_store_buffer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared word/address widths and the store-buffer entry type.
//               WORD_W   - data word width
//               ADDR_W   - byte-address width
//               ADDR_LSB - first bit of the word index inside a byte address
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int WORD_W   = 32;
    localparam int ADDR_W   = 32;
    localparam int ADDR_LSB = 2;

    // One buffered store: word index plus the full data word.
    typedef struct packed {
        logic [ADDR_W-1:ADDR_LSB] wadr;
        logic [WORD_W-1:0]        data;
    } sb_entry_t;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/sb_fwd_select.sv
`default_nettype none
// ============================================================================
// Module      : sb_fwd_select
// Description : Load-forwarding selector. Finds the youngest valid entry whose
//               word index equals the lookup index.
//   i_entries  - entry array
//   i_valid    - per-entry valid mask
//   i_wr_ptr   - next write slot (youngest entry is i_wr_ptr-1)
//   i_wadr     - lookup word index
//   o_hit      - some valid entry matches
//   o_hit_data - data of the youngest matching entry
// Revision    : 1.0 - initial release
// ============================================================================
module sb_fwd_select
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH)
) (
    input  sb_entry_t                i_entries [DEPTH],
    input  logic [DEPTH-1:0]         i_valid,
    input  logic [PW-1:0]            i_wr_ptr,
    input  logic [ADDR_W-1:ADDR_LSB] i_wadr,
    output logic                     o_hit,
    output logic [WORD_W-1:0]        o_hit_data
);

    // Walk from oldest (wr_ptr-DEPTH) to youngest (wr_ptr-1); a later match
    // overwrites an earlier one, so the youngest match wins.
    always_comb begin
        logic [PW-1:0] w_idx;
        o_hit      = 1'b0;
        o_hit_data = '0;
        w_idx      = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            w_idx = i_wr_ptr - PW'(k);
            if (i_valid[w_idx] && (i_entries[w_idx].wadr == i_wadr)) begin
                o_hit      = 1'b1;
                o_hit_data = i_entries[w_idx].data;
            end
        end
    end

endmodule : sb_fwd_select
`default_nettype wire

// File: rtl/dmem_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : dmem_store_buffer
// Description : Posted-write store buffer between the CPU data port and dmem.
//               Stores enter a DEPTH-entry FIFO and drain one per accepted
//               memory write, in order. Loads forward from the youngest
//               buffered store to the same word, else return mem_rd.
//   clk / reset      - clock, asynchronous active-low reset
//   cpu_we/adr/wd    - store request (adr also addresses loads)
//   cpu_rd           - load data (forwarded or mem_rd)
//   cpu_stall        - store not accepted this cycle
//   mem_we/adr/wd    - head-entry write to dmem
//   mem_ready        - dmem accepts the write this cycle
//   mem_rd           - dmem read data for cpu_adr
//   empty            - no buffered stores
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_store_buffer
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = WORD_W,   // must match WORD_W (entry type width)
    parameter int AW    = ADDR_W    // must match ADDR_W (entry type width)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_adr,
    input  logic [DW-1:0] cpu_wd,
    output logic [DW-1:0] cpu_rd,
    output logic          cpu_stall,
    output logic          mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wd,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_rd,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;         // count spans 0..DEPTH

    sb_entry_t        r_entries [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic [DEPTH-1:0] w_valid;
    logic [PW-1:0]    w_off [DEPTH];
    logic             w_hit;
    logic [DW-1:0]    w_hit_data;
    logic             w_unused_lsb;

    assign w_full    = (r_count == CW'(DEPTH));
    assign mem_we    = (r_count != '0);
    assign w_pop     = mem_we & mem_ready;
    // A full buffer still accepts a store when the head drains in the same cycle.
    assign w_push    = cpu_we & (~w_full | w_pop);
    assign cpu_stall = cpu_we & w_full & ~w_pop;
    assign empty     = (r_count == '0);

    assign mem_adr   = {r_entries[r_rd_ptr].wadr, 2'b00};
    assign mem_wd    = r_entries[r_rd_ptr].data;

    // Slot i is valid when its distance from the head is below count.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
        assign w_off[gi]   = PW'(gi) - r_rd_ptr;
        assign w_valid[gi] = ({1'b0, w_off[gi]} < r_count);
    end

    sb_fwd_select #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_fwd (
        .i_entries  (r_entries),
        .i_valid    (w_valid),
        .i_wr_ptr   (r_wr_ptr),
        .i_wadr     (cpu_adr[AW-1:ADDR_LSB]),
        .o_hit      (w_hit),
        .o_hit_data (w_hit_data)
    );

    // Uses pre-edge state only, so a store pushed this cycle is not yet visible.
    assign cpu_rd = w_hit ? w_hit_data : mem_rd;

    // Accesses are word-only; the byte offset is deliberately unused.
    assign w_unused_lsb = ^cpu_adr[ADDR_LSB-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_entries[r_wr_ptr] <= '{wadr: cpu_adr[AW-1:ADDR_LSB], data: cpu_wd};
                r_wr_ptr            <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : dmem_store_buffer
`default_nettype wire

// File: tb/tb_dmem_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_store_buffer
// Description : Self-checking bench for dmem_store_buffer: a vector table for
//               store/forward/drain behaviour plus directed sequences for
//               reset, full-buffer stall, ready toggling and streaming.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_store_buffer;

    logic        clk;
    logic        reset;
    logic        cpu_we;
    logic [31:0] cpu_adr;
    logic [31:0] cpu_wd;
    logic [31:0] cpu_rd;
    logic        cpu_stall;
    logic        mem_we;
    logic [31:0] mem_adr;
    logic [31:0] mem_wd;
    logic        mem_ready;
    logic [31:0] mem_rd;
    logic        empty;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Data memory model: 256 words, combinational read, written at the edge.
    logic [31:0] dmem [256];
    logic        r_pend;
    logic [31:0] r_pend_adr;
    logic [31:0] r_pend_wd;

    // Record of every write dmem accepted: address, data, cycle.
    logic [31:0] log_adr[$];
    logic [31:0] log_wd[$];
    int          log_cyc[$];

    assign mem_rd = dmem[cpu_adr[9:2]];

    dmem_store_buffer #(.DEPTH(4), .DW(32), .AW(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_we    (cpu_we),
        .cpu_adr   (cpu_adr),
        .cpu_wd    (cpu_wd),
        .cpu_rd    (cpu_rd),
        .cpu_stall (cpu_stall),
        .mem_we    (mem_we),
        .mem_adr   (mem_adr),
        .mem_wd    (mem_wd),
        .mem_ready (mem_ready),
        .mem_rd    (mem_rd),
        .empty     (empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Capture the write mid-cycle (inputs stable), commit it at the edge.
    always @(negedge clk) begin
        r_pend = mem_we && mem_ready;
        if (r_pend) begin
            r_pend_adr = mem_adr;
            r_pend_wd  = mem_wd;
            log_adr.push_back(mem_adr);
            log_wd.push_back(mem_wd);
            log_cyc.push_back(cyc);
        end
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (r_pend) dmem[r_pend_adr[9:2]] = r_pend_wd;
        r_pend = 1'b0;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wd;
        logic        rdy;
        logic        e_stall;
        logic        e_mwe;
        logic [31:0] e_madr;
        logic [31:0] e_mwd;
        logic        e_empty;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vt[11];

    function automatic vec_t mk(logic we, logic [31:0] adr, logic [31:0] wd, logic rdy,
                                logic st, logic mwe, logic [31:0] madr, logic [31:0] mwd,
                                logic emp, logic [31:0] rd);
        vec_t v;
        v.we = we; v.adr = adr; v.wd = wd; v.rdy = rdy;
        v.e_stall = st; v.e_mwe = mwe; v.e_madr = madr; v.e_mwd = mwd;
        v.e_empty = emp; v.e_rd = rd;
        return v;
    endfunction

    initial begin
        int base;
        int c0;
        logic [31:0] exp_a;

        for (int i = 0; i < 256; i++) dmem[i] = 32'hA000_0000 + i;
        r_pend = 1'b0;
        r_pend_adr = '0;
        r_pend_wd = '0;

        // Table: single store/drain, then two stores to one word with forwarding.
        //          we  adr    wd  rdy st mwe madr   mwd emp rd
        vt[0]  = mk(1, 32'd84, 7, 1,  0, 0,  0,     0,  1, 32'hA000_0015);
        vt[1]  = mk(0, 32'd84, 0, 1,  0, 1,  84,    7,  0, 7);
        vt[2]  = mk(0, 32'd84, 0, 1,  0, 0,  0,     0,  1, 7);
        vt[3]  = mk(1, 32'd80, 5, 0,  0, 0,  0,     0,  1, 32'hA000_0014);
        vt[4]  = mk(1, 32'd80, 9, 0,  0, 1,  80,    5,  0, 5);
        vt[5]  = mk(0, 32'd80, 0, 0,  0, 1,  80,    5,  0, 9);
        vt[6]  = mk(0, 32'd82, 0, 0,  0, 1,  80,    5,  0, 9);
        vt[7]  = mk(0, 32'd88, 0, 0,  0, 1,  80,    5,  0, 32'hA000_0016);
        vt[8]  = mk(0, 32'd80, 0, 1,  0, 1,  80,    5,  0, 9);
        vt[9]  = mk(0, 32'd80, 0, 1,  0, 1,  80,    9,  0, 9);
        vt[10] = mk(0, 32'd80, 0, 1,  0, 0,  0,     0,  1, 9);

        // Reset state
        reset = 1'b0; cpu_we = 1'b0; cpu_adr = '0; cpu_wd = '0; mem_ready = 1'b1;
        #2;
        chk("reset_empty", {31'd0, empty}, 32'd1);
        chk("reset_mem_we", {31'd0, mem_we}, 32'd0);
        chk("reset_stall", {31'd0, cpu_stall}, 32'd0);
        next_cycle();
        next_cycle();
        reset = 1'b1;
        next_cycle();

        // Table-driven vectors
        for (int i = 0; i < 11; i++) begin
            cpu_we = vt[i].we; cpu_adr = vt[i].adr; cpu_wd = vt[i].wd; mem_ready = vt[i].rdy;
            #2;
            chk($sformatf("v%0d_stall", i), {31'd0, cpu_stall}, {31'd0, vt[i].e_stall});
            chk($sformatf("v%0d_mem_we", i), {31'd0, mem_we}, {31'd0, vt[i].e_mwe});
            if (vt[i].e_mwe) begin
                chk($sformatf("v%0d_mem_adr", i), mem_adr, vt[i].e_madr);
                chk($sformatf("v%0d_mem_wd", i), mem_wd, vt[i].e_mwd);
            end
            chk($sformatf("v%0d_empty", i), {31'd0, empty}, {31'd0, vt[i].e_empty});
            chk($sformatf("v%0d_cpu_rd", i), cpu_rd, vt[i].e_rd);
            next_cycle();
        end
        chk("table_write_count", log_adr.size(), 3);

        // Reset with two stores pending: discarded, no writes afterwards.
        mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cpu_we = 1'b1; cpu_adr = 32'h200 + 4 * i; cpu_wd = 32'h77 + i;
            next_cycle();
        end
        cpu_we = 1'b0;
        #1;
        chk("pend_empty", {31'd0, empty}, 32'd0);
        reset = 1'b0;
        #1;
        chk("rst2_empty", {31'd0, empty}, 32'd1);
        chk("rst2_mem_we", {31'd0, mem_we}, 32'd0);
        next_cycle();
        reset = 1'b1;
        base = log_adr.size();
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) next_cycle();
        chk("rst2_no_writes", log_adr.size(), base);
        chk("rst2_still_empty", {31'd0, empty}, 32'd1);

        // Full buffer: 5th store stalls until mem_ready rises.
        mem_ready = 1'b0;
        base = log_adr.size();
        for (int i = 0; i < 4; i++) begin
            cpu_we = 1'b1; cpu_adr = 4 * i; cpu_wd = 32'h30 + i;
            #2;
            chk($sformatf("fill%0d_stall", i), {31'd0, cpu_stall}, 32'd0);
            next_cycle();
        end
        cpu_adr = 32'd16; cpu_wd = 32'h34;
        #1;
        chk("full_stall", {31'd0, cpu_stall}, 32'd1);
        next_cycle();
        chk("full_stall_hold", {31'd0, cpu_stall}, 32'd1);
        chk("full_head_adr", mem_adr, 32'd0);
        #1;
        mem_ready = 1'b1;
        #1;
        chk("full_pop_stall", {31'd0, cpu_stall}, 32'd0);
        next_cycle();
        mem_ready = 1'b0; cpu_adr = 32'd20; cpu_wd = 32'h99;
        #1;
        chk("still_full_stall", {31'd0, cpu_stall}, 32'd1);
        chk("new_head_adr", mem_adr, 32'd4);
        chk("new_head_wd", mem_wd, 32'h31);
        cpu_we = 1'b0;
        mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) next_cycle();
        chk("full_drained", {31'd0, empty}, 32'd1);
        chk("full_write_count", log_adr.size() - base, 5);
        for (int i = 0; i < 5 && base + i < log_adr.size(); i++) begin
            chk($sformatf("full_w%0d_adr", i), log_adr[base + i], 4 * i);
            chk($sformatf("full_w%0d_wd", i), log_wd[base + i], 32'h30 + i);
        end

        // mem_ready toggling: writes only in ready cycles, in order.
        base = log_adr.size();
        c0 = cyc;
        for (int i = 0; i < 8; i++) begin
            mem_ready = (i % 2 == 0);
            cpu_we = (i < 3);
            cpu_adr = 32'h40 + 4 * i;
            cpu_wd = i + 1;
            next_cycle();
        end
        cpu_we = 1'b0;
        chk("tog_write_count", log_adr.size() - base, 3);
        for (int i = 0; i < 3 && base + i < log_adr.size(); i++) begin
            chk($sformatf("tog_w%0d_adr", i), log_adr[base + i], 32'h40 + 4 * i);
            chk($sformatf("tog_w%0d_wd", i), log_wd[base + i], i + 1);
            chk($sformatf("tog_w%0d_cyc", i), log_cyc[base + i], c0 + 2 + 2 * i);
        end

        // Streaming at mem_ready=1: never stalls, at most one entry held.
        mem_ready = 1'b1;
        base = log_adr.size();
        for (int i = 0; i < 10; i++) begin
            cpu_we = 1'b1; cpu_adr = 32'h100 + 4 * i; cpu_wd = 32'h600 + i;
            #1;
            chk($sformatf("str%0d_stall", i), {31'd0, cpu_stall}, 32'd0);
            if (i > 0) begin
                exp_a = 32'h100 + 4 * (i - 1);
                chk($sformatf("str%0d_head", i), mem_adr, exp_a);
            end
            next_cycle();
        end
        cpu_we = 1'b0;
        #1;
        chk("str_last_head", mem_adr, 32'h124);
        next_cycle();
        chk("str_empty", {31'd0, empty}, 32'd1);
        chk("str_write_count", log_adr.size() - base, 10);
        for (int i = 0; i < 10 && base + i < log_adr.size(); i++) begin
            chk($sformatf("str_w%0d_adr", i), log_adr[base + i], 32'h100 + 4 * i);
            chk($sformatf("str_w%0d_wd", i), log_wd[base + i], 32'h600 + i);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_dmem_store_buffer
`default_nettype wire
